// File: rtl/frame_bit_reducer.sv
// frame_bit_reducer: folds every bit of a frame into one bit through a serial
// chain of a selectable Boolean operator. Words arrive over a valid/ready input
// and the frame result is presented over a valid/ready output.
// Optional feature: define FRAME_BIT_REDUCER_WORD_COUNT_EN to add the
// saturating word counter and the out_word_count port.

// One link of the serial chain: p_out = op(p_in, b) when en, else p_in.
module frame_bit_reducer_step #(
    parameter int OP = 5
) (
    input  logic p_in,
    input  logic b,
    input  logic en,
    output logic p_out
);
    // Disabled links pass the seed straight through.
    always_comb begin
        p_out = p_in;
        if (en) begin
            case (OP)
                0:       p_out = p_in & b;
                1:       p_out = ~(p_in & b);
                2:       p_out = p_in | b;
                3:       p_out = ~(p_in | b);
                4:       p_out = p_in ^ b;
                5:       p_out = ~(p_in ^ b);
                default: p_out = 1'b0;
            endcase
        end
    end
endmodule

module frame_bit_reducer #(
    parameter string OPERATION   = "XNOR",
    parameter int    WORD_WIDTH  = 8,
    parameter int    COUNT_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] out_word_count
`endif
);
    localparam int OP_SEL = (OPERATION == "AND")  ? 0 :
                            (OPERATION == "NAND") ? 1 :
                            (OPERATION == "OR")   ? 2 :
                            (OPERATION == "NOR")  ? 3 :
                            (OPERATION == "XOR")  ? 4 :
                            (OPERATION == "XNOR") ? 5 : -1;

    typedef enum logic {ACCUMULATE, HOLD} state_t;

    state_t state, state_next;
    logic   have_seed;  // chain already holds a seed for the current frame
    logic   acc;        // running chain value between words
    logic   fold;       // chain value after folding in_data
    logic   in_fire, out_fire;

    assign in_ready  = (state == ACCUMULATE) || out_ready;
    assign out_valid = (state == HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Serial chain across the word; bit 0 seeds a fresh frame, otherwise the
    // carried accumulator enters the first link. Every link applies the full
    // operator, so inverting operators invert at each step.
    generate
        if (OP_SEL >= 0) begin : g_chain
            logic [WORD_WIDTH:0] chain;
            assign chain[0] = have_seed ? acc : in_data[0];
            for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_link
                frame_bit_reducer_step #(.OP(OP_SEL)) u_step (
                    .p_in (chain[i]),
                    .b    (in_data[i]),
                    .en   ((i == 0) ? have_seed : 1'b1),
                    .p_out(chain[i+1])
                );
            end
            assign fold = chain[WORD_WIDTH];
        end else begin : g_no_chain
            assign fold = 1'b0;
        end
    endgenerate

    // Next state: the last word moves to HOLD; leaving HOLD either starts a
    // new frame with the concurrent word or re-arms for one.
    always_comb begin
        state_next = state;
        case (state)
            ACCUMULATE: if (in_fire && in_last) state_next = HOLD;
            HOLD: begin
                if (out_fire) state_next = (in_fire && in_last) ? HOLD : ACCUMULATE;
            end
            default: state_next = ACCUMULATE;
        endcase
    end

    // State, chain accumulator and registered frame result.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= ACCUMULATE;
            have_seed <= 1'b0;
            acc       <= 1'b0;
            out_bit   <= 1'b0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                if (in_last) begin
                    out_bit   <= fold;
                    have_seed <= 1'b0;
                    acc       <= 1'b0;
                end else begin
                    acc       <= fold;
                    have_seed <= 1'b1;
                end
            end else if (out_fire) begin
                have_seed <= 1'b0;
            end
        end
    end

`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] cnt_inc;

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    // Saturating count of accepted words; latched with the result on the last word.
    always_ff @(posedge clock) begin
        if (clear) begin
            cnt            <= '0;
            out_word_count <= '0;
        end else if (in_fire) begin
            if (in_last) begin
                cnt            <= '0;
                out_word_count <= cnt_inc;
            end else begin
                cnt <= cnt_inc;
            end
        end else if (out_fire) begin
            cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_frame_bit_reducer.sv
// Scoreboard bench for frame_bit_reducer: four instances with different
// operator/width settings; only one is driven at a time so a single ordered
// queue of expected results serves all of them.
module tb_frame_bit_reducer;
    logic clock;
    logic clear;
    logic [3:0]      in_valid, in_last, out_ready;
    logic [3:0][3:0] in_data;
    wire  [3:0]      in_ready, out_valid, out_bit;

    string OPS [4] = '{"NAND", "XNOR", "XNOR", "XOR"};
    int    WS  [4] = '{4, 3, 4, 4};
    int    CM  [4] = '{255, 255, 255, 3};

    typedef struct {
        int   k;
        logic b;
        int   cnt;
    } exp_t;

    exp_t sb[$];
    bit   cur_bits[$];
    int   cur_cnt = 0;
    int   total = 0;
    int   bad = 0;
    bit   rand_bp = 0;

`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
    wire [7:0] cnt0, cnt1, cnt2;
    wire [1:0] cnt3;
`endif

    frame_bit_reducer #(.OPERATION("NAND"), .WORD_WIDTH(4), .COUNT_WIDTH(8)) u_dut0 (
        .clock(clock), .clear(clear), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_bit(out_bit[0])
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
        , .out_word_count(cnt0)
`endif
    );
    frame_bit_reducer #(.OPERATION("XNOR"), .WORD_WIDTH(3), .COUNT_WIDTH(8)) u_dut1 (
        .clock(clock), .clear(clear), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1][2:0]), .in_last(in_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_bit(out_bit[1])
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
        , .out_word_count(cnt1)
`endif
    );
    frame_bit_reducer #(.OPERATION("XNOR"), .WORD_WIDTH(4), .COUNT_WIDTH(8)) u_dut2 (
        .clock(clock), .clear(clear), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_bit(out_bit[2])
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
        , .out_word_count(cnt2)
`endif
    );
    frame_bit_reducer #(.OPERATION("XOR"), .WORD_WIDTH(4), .COUNT_WIDTH(2)) u_dut3 (
        .clock(clock), .clear(clear), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .in_last(in_last[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .out_bit(out_bit[3])
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
        , .out_word_count(cnt3)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
    function automatic int dut_cnt(input int k);
        case (k)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction
`endif

    // Reference: left fold of the operator over the frame's bit list.
    function automatic logic ref_reduce(input string op, input bit bits[$]);
        logic p;
        p = bits[0];
        for (int i = 1; i < bits.size(); i++) begin
            case (op)
                "AND":  p = p & bits[i];
                "NAND": p = !(p && bits[i]);
                "OR":   p = p | bits[i];
                "NOR":  p = !(p || bits[i]);
                "XOR":  p = p ^ bits[i];
                default: p = (p == bits[i]);
            endcase
        end
        return p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (rand_bp) out_ready = 4'($urandom_range(0, 15));
    endtask

    task automatic model_accept(input int k, input logic [3:0] d, input logic last);
        for (int i = 0; i < WS[k]; i++) cur_bits.push_back(d[i]);
        if (cur_cnt < CM[k]) cur_cnt++;
        if (last) begin
            sb.push_back('{k, ref_reduce(OPS[k], cur_bits), cur_cnt});
            cur_bits.delete();
            cur_cnt = 0;
        end
    endtask

    // Present one word until accepted; ov reports out_valid in the accept cycle.
    task automatic send(input int k, input logic [3:0] d, input logic last, output logic ov);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        ov = 1'b0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_last[k]  = last;
        while (!done) begin
            @(negedge clock);
            done = in_ready[k];
            if (done) begin
                ov = out_valid[k];
                model_accept(k, d, last);
            end
            step();
            n++;
            if (!done && n > 200) begin
                check("send_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_bp = 0;
        out_ready = '1;
        while (sb.size() > 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: every output transfer pops and compares one expected result.
    always @(negedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && out_ready[k] && !clear) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", k, -1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_dut", k, e.k);
                    check("sb_bit", int'(out_bit[k]), int'(e.b));
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
                    check("sb_count", dut_cnt(k), e.cnt);
`endif
                end
            end
        end
    end

    initial begin
        logic ov;
        logic held;
        int   len;
        clear = 1'b1;
        in_valid = '0;
        in_last = '0;
        in_data = '0;
        out_ready = '1;
        step();
        step();
        clear = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            check("reset_out_valid", int'(out_valid[k]), 0);
            check("reset_in_ready", int'(in_ready[k]), 1);
            check("reset_out_bit", int'(out_bit[k]), 0);
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
            check("reset_count", dut_cnt(k), 0);
`endif
        end
        step();

        // NAND, 4 bits: 1111 -> 0, then 0111 -> 1
        out_ready[0] = 1'b0;
        send(0, 4'b1111, 1'b1, ov);
        @(negedge clock);
        check("nand_1111_valid", int'(out_valid[0]), 1);
        check("nand_1111_bit", int'(out_bit[0]), 0);
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
        check("nand_1111_count", dut_cnt(0), 1);
`endif
        step();
        out_ready[0] = 1'b1;
        send(0, 4'b0111, 1'b1, ov);
        @(negedge clock);
        check("nand_0111_bit", int'(out_bit[0]), 1);
        step();

        // XNOR, 3 bits: 000 -> 0
        send(1, 4'b0000, 1'b1, ov);
        @(negedge clock);
        check("xnor3_000_bit", int'(out_bit[1]), 0);
        step();

        // XNOR, 4 bits: two zero words -> 1, count 2, valid one cycle later
        send(2, 4'b0000, 1'b0, ov);
        send(2, 4'b0000, 1'b1, ov);
        check("xnor_valid_low_at_last", int'(ov), 0);
        @(negedge clock);
        check("xnor_valid_next_cycle", int'(out_valid[2]), 1);
        check("xnor_2w_bit", int'(out_bit[2]), 1);
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
        check("xnor_2w_count", dut_cnt(2), 2);
`endif
        step();

        // XOR with 2-bit counter: five words of 0001 -> 1, count saturates at 3
        out_ready[3] = 1'b0;
        for (int i = 0; i < 5; i++) send(3, 4'b0001, (i == 4), ov);
        @(negedge clock);
        check("xor_sat_bit", int'(out_bit[3]), 1);
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
        check("xor_sat_count", dut_cnt(3), 3);
`endif
        step();
        out_ready[3] = 1'b1;
        drain();

        // HOLD with backpressure, then release together with a new frame
        out_ready[2] = 1'b0;
        send(2, 4'($urandom), 1'b1, ov);
        @(negedge clock);
        held = out_bit[2];
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            check("hold_in_ready", int'(in_ready[2]), 0);
            check("hold_out_valid", int'(out_valid[2]), 1);
            check("hold_out_bit", int'(out_bit[2]), int'(held));
            step();
        end
        out_ready[2] = 1'b1;
        send(2, 4'($urandom), 1'b1, ov);
        send(2, 4'($urandom), 1'b1, ov);
        drain();

        // clear mid-frame discards the partial frame
        send(0, 4'($urandom), 1'b0, ov);
        send(0, 4'($urandom), 1'b0, ov);
        clear = 1'b1;
        step();
        clear = 1'b0;
        cur_bits.delete();
        cur_cnt = 0;
        @(negedge clock);
        check("clear_mid_valid", int'(out_valid[0]), 0);
        step();
        send(0, 4'($urandom), 1'b1, ov);
        drain();

        // clear in HOLD drops the pending result
        out_ready[0] = 1'b0;
        send(0, 4'($urandom), 1'b1, ov);
        clear = 1'b1;
        step();
        clear = 1'b0;
        void'(sb.pop_back());
        @(negedge clock);
        check("clear_hold_valid", int'(out_valid[0]), 0);
        check("clear_hold_bit", int'(out_bit[0]), 0);
`ifdef FRAME_BIT_REDUCER_WORD_COUNT_EN
        check("clear_hold_count", dut_cnt(0), 0);
`endif
        step();
        out_ready[0] = 1'b1;

        // Random frames with random output backpressure
        for (int k = 0; k < 4; k++) begin
            rand_bp = 1;
            for (int f = 0; f < 25; f++) begin
                len = $urandom_range(1, 6);
                for (int w = 0; w < len; w++) begin
                    send(k, 4'($urandom), (w == len - 1), ov);
                    if ($urandom_range(0, 3) == 0) step();
                end
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
